// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: default bit timing (kept in one
// place so TX and RX stay matched), FSM state encodings and the 2-of-3 vote
// helper used when UART_RX_MAJORITY_EN is defined.
package uart_rx_pkg;

  // Clocks per serial bit; the transmitter uses the same value.
  localparam int DEFAULT_BITCYCLES = 101;
  localparam int DATABITS          = 8;

  // Receiver FSM state encodings.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_STOP     = 3'd3;
  localparam logic [2:0] ST_WAITHIGH = 3'd4;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input. Both flops reset
// to 1 (the idle line level) so leaving reset never looks like a start edge.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw line through two flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (LSB first, idle high). Finds the start edge, samples each
// bit in its middle, checks the stop bit and offers the byte on a valid/ready
// port with frame-error and overrun pulses.
// Optional build macro UART_RX_MAJORITY_EN: every sample point becomes a
// 2-of-3 vote over offset-1/offset/offset+1, decided at offset+1.
//
// Handshake: RXVALID rises when a byte is delivered and holds RXDATA stable
// until a posedge sees RXVALID & RXREADY; a delivery in that same cycle
// replaces the byte and keeps RXVALID high, while a delivery with RXVALID
// high and RXREADY low drops the new byte and pulses OVERRUN.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BITCYCLES  = DEFAULT_BITCYCLES,
  parameter int HALFCYCLES = BITCYCLES / 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UARTRX,
  output logic [7:0] RXDATA,
  output logic       RXVALID,
  input  logic       RXREADY,
  output logic       FRAMEERR,
  output logic       OVERRUN,
  output logic       BUSY,
  output logic [2:0] dbg_state_o
);

  localparam int CW = $clog2(BITCYCLES);
  // Counter value at which a sample is taken. The counter is reloaded to 0 at
  // every sample, so one bit later it reads BITCYCLES-1 again.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_PT = CW'(HALFCYCLES);
`else
  localparam logic [CW-1:0] START_PT = CW'(HALFCYCLES - 1);
`endif
  localparam logic [CW-1:0] BIT_PT = CW'(BITCYCLES - 1);

  logic          rx_s;
  logic          sample;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          deliver;
  logic          frame_err;
  logic [7:0]    rxdata_q;
  logic          rxvalid_q;
  logic          frameerr_q;
  logic          overrun_q;

  uart_rx_sync u_sync (
    .clk_i  (CLK),
    .rst_i  (RST),
    .rx_i   (UARTRX),
    .rx_s_o (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic hist1_q, hist2_q;

  // Keep the two previous synchronised samples for the vote.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= rx_s;
      hist2_q <= hist1_q;
    end
  end

  assign sample = maj3(hist2_q, hist1_q, rx_s);
`else
  assign sample = rx_s;
`endif

  // Frame FSM: start detect, mid-bit sampling, stop check.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == BIT_PT) ? '0 : cnt_q + CW'(1);
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d  = ST_START;
          bitcnt_d = 3'd0;
        end
      end
      ST_START: begin
        if (cnt_q == START_PT) begin
          cnt_d   = '0;
          // A start bit that is high again by mid-bit was a glitch.
          state_d = sample ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_PT) begin
          cnt_d    = '0;
          shift_d  = {sample, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'(DATABITS - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_PT) begin
          cnt_d = '0;
          if (sample) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = ST_WAITHIGH;
          end
        end
      end
      ST_WAITHIGH: begin
        // A break or stuck-low line must not be read as a new start bit.
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, counters and shift register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
    end
  end

  // Output port: byte delivery, handshake, error pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rxdata_q   <= 8'h00;
      rxvalid_q  <= 1'b0;
      frameerr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      frameerr_q <= frame_err;
      overrun_q  <= 1'b0;
      if (deliver) begin
        if (rxvalid_q && !RXREADY) begin
          overrun_q <= 1'b1;
        end else begin
          rxdata_q  <= shift_q;
          rxvalid_q <= 1'b1;
        end
      end else if (rxvalid_q && RXREADY) begin
        rxvalid_q <= 1'b0;
      end
    end
  end

  assign RXDATA      = rxdata_q;
  assign RXVALID     = rxvalid_q;
  assign FRAMEERR    = frameerr_q;
  assign OVERRUN     = overrun_q;
  assign BUSY        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frame with latency check, back-to-back
// frames, start glitch, framing error with stuck-low line, overrun, reset
// mid-frame and a one-cycle mid-bit glitch. Honours UART_RX_MAJORITY_EN.
module tb_uart_rx;

  localparam int BIT = 101;
`ifdef UART_RX_MAJORITY_EN
  localparam int         LAT        = 963;
  localparam logic [7:0] GLITCH_EXP = 8'hA5;
`else
  localparam int         LAT        = 962;
  localparam logic [7:0] GLITCH_EXP = 8'hA1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       uartrx;
  logic       rxready;
  logic [7:0] rxdata;
  logic       rxvalid;
  logic       frameerr;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise_cyc  = 0;
  int rise_cnt  = 0;
  int frameerr_cnt = 0;
  int overrun_cnt  = 0;
  int busy_seen    = 0;
  logic valid_prev = 1'b0;
  int b_rise, b_fe, b_ov, b_busy;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_rx dut (
    .CLK         (clk),
    .RST         (rst),
    .UARTRX      (uartrx),
    .RXDATA      (rxdata),
    .RXVALID     (rxvalid),
    .RXREADY     (rxready),
    .FRAMEERR    (frameerr),
    .OVERRUN     (overrun),
    .BUSY        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: transfers, pulses, RXVALID rise time.
  always @(negedge clk) begin
    if (rxvalid && rxready) got_q.push_back(rxdata);
    if (frameerr) frameerr_cnt++;
    if (overrun) overrun_cnt++;
    if (busy) busy_seen++;
    if (rxvalid && !valid_prev) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    valid_prev = rxvalid;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_data"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drive n_cycles of an 8N1 frame; optionally invert the line for the one
  // cycle at (period gp, cycle gc). Called 2 time units after a posedge.
  task automatic drive_frame(input logic [7:0] data, input logic stop_bit, input int n_cycles,
                             input int gp, input int gc);
    logic [9:0] frame;
    int j;
    int c;
    frame = {stop_bit, data, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < n_cycles; i++) begin
      j = i / BIT;
      c = i % BIT;
      uartrx = frame[j] ^ ((j == gp) && (c == gc));
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] data);
    drive_frame(data, 1'b1, 10 * BIT, -1, -1);
  endtask

  task automatic snap();
    b_rise = rise_cnt;
    b_fe   = frameerr_cnt;
    b_ov   = overrun_cnt;
    b_busy = busy_seen;
  endtask

  initial begin
    rst     = 1'b1;
    uartrx  = 1'b1;
    rxready = 1'b1;
    wait_cycles(3);
    check("rst_rxdata", rxdata, 8'h00);
    check("rst_rxvalid", rxvalid, 1'b0);
    check("rst_frameerr", frameerr, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    rst = 1'b0;
    wait_cycles(20);

    // 1: clean 0xA5 with ready high.
    snap();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    wait_cycles(5);
    check("t1_latency", rise_cyc - start_cyc, LAT);
    check("t1_rises", rise_cnt - b_rise, 1);
    check("t1_frameerr", frameerr_cnt - b_fe, 0);
    check("t1_overrun", overrun_cnt - b_ov, 0);
    check_queues("t1");

    // 2: back-to-back 0x00 then 0xFF with no idle gap.
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00);
    send_byte(8'hFF);
    wait_cycles(5);
    check("t2_rises", rise_cnt - b_rise, 2);
    check("t2_frameerr", frameerr_cnt - b_fe, 0);
    check_queues("t2");

    // 3: 20-cycle low glitch is rejected at the start-bit sample.
    snap();
    uartrx = 1'b0;
    wait_cycles(20);
    uartrx = 1'b1;
    wait_cycles(100);
    check("t3_busy_seen", busy_seen > b_busy, 1);
    check("t3_idle", dbg_state, 3'd0);
    check("t3_rises", rise_cnt - b_rise, 0);
    check("t3_frameerr", frameerr_cnt - b_fe, 0);
    check_queues("t3");

    // 4: 0x3C with stop bit 0, line then held low.
    snap();
    drive_frame(8'h3C, 1'b0, 10 * BIT, -1, -1);
    wait_cycles(300);
    check("t4_busy_low_line", busy, 1'b1);
    check("t4_waithigh", dbg_state, 3'd4);
    check("t4_frameerr", frameerr_cnt - b_fe, 1);
    check("t4_rises", rise_cnt - b_rise, 0);
    uartrx = 1'b1;
    wait_cycles(6);
    check("t4_busy_after_high", busy, 1'b0);
    check_queues("t4");

    // 5: overrun with ready low, then accept.
    snap();
    rxready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    wait_cycles(5);
    check("t5_rxdata_held", rxdata, 8'h11);
    check("t5_rxvalid_held", rxvalid, 1'b1);
    check("t5_overrun", overrun_cnt - b_ov, 1);
    check("t5_rises", rise_cnt - b_rise, 1);
    exp_q.push_back(8'h11);
    rxready = 1'b1;
    wait_cycles(3);
    check("t5_rxvalid_fell", rxvalid, 1'b0);
    check_queues("t5");

    // 6: reset during bit 4 of 0x5A, then 0xC3.
    snap();
    drive_frame(8'h5A, 1'b1, 5 * BIT + 50, -1, -1);
    rst = 1'b1;
    wait_cycles(3);
    check("t6_rst_rxdata", rxdata, 8'h00);
    check("t6_rst_rxvalid", rxvalid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_state", dbg_state, 3'd0);
    uartrx = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(20);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    wait_cycles(5);
    check("t6_rises", rise_cnt - b_rise, 1);
    check_queues("t6");

    // 7: one-cycle glitch at the sample point of data bit 2 of 0xA5.
    snap();
    exp_q.push_back(GLITCH_EXP);
    drive_frame(8'hA5, 1'b1, 10 * BIT, 3, 50);
    wait_cycles(5);
    check("t7_frameerr", frameerr_cnt - b_fe, 0);
    check_queues("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
